bkg_subtract: RTL and testbench

BKG_SUBTRACT -- requirements
Module: bkg_subtract

---
 rtl/bkg_subtract_pkg.sv | 21 ++
 rtl/bkg_subtract_if.sv | 11 +
 rtl/bkg_subtract_sat_sub16.sv | 12 +
 rtl/bkg_subtract.sv | 182 ++++++++++++++++++
 tb/tb_bkg_subtract.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bkg_subtract_pkg.sv
// Shared types and widths for the background-subtraction datapath.
package bkg_subtract_pkg;

  localparam int HALF_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Unsigned add of a sample half into an accumulator, clamping at all-ones.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0]  acc,
                                               input logic [HALF_W-1:0] inc);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W+1-HALF_W){1'b0}}, inc};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/bkg_subtract_if.sv
// Sample beat bus: packed A/B data, qualifier and channel index.
interface bkg_subtract_if;
  import bkg_subtract_pkg::*;

  logic [2*HALF_W-1:0] data;
  logic                valid;
  logic [7:0]          address;

  modport master (output data, valid, address);
  modport slave  (input  data, valid, address);
endinterface

// File: rtl/bkg_subtract_sat_sub16.sv
// One 16-bit half of the subtractor: result clamps at zero instead of wrapping.
module sat_sub16
  import bkg_subtract_pkg::*;
(
  input  logic [HALF_W-1:0] raw,
  input  logic [HALF_W-1:0] bkg,
  output logic [HALF_W-1:0] diff
);

  assign diff = (raw >= bkg) ? (raw - bkg) : '0;

endmodule

// File: rtl/bkg_subtract.sv
// Background subtraction with per-frame sums and peak-channel search.
//
// state    | meaning
// ST_IDLE  | waiting for an aligned beat with address 0
// ST_ACCUM | accumulating a frame, expecting sequential addresses
// ST_DONE  | last channel seen; results publish on the next clock
module bkg_subtract
  import bkg_subtract_pkg::*;
#(
  parameter int N_CH    = 192,
  parameter int BKG_LAT = 2
) (
  input  logic             clk_clk,
  input  logic             rst_reset,
  input  logic             enable,
  bkg_subtract_if.slave    data_in,
  output logic [7:0]       bkg_rd_address,
  input  logic [31:0]      bkg_signal,
  input  logic             bkg_sub_status,
  bkg_subtract_if.master   data_out,
  output logic [ACC_W-1:0] frame_sum_a,
  output logic [ACC_W-1:0] frame_sum_b,
  output logic [7:0]       frame_peak_addr,
  output logic             frame_done,
  output logic             frame_err,
  output logic             sub_active
);

  localparam logic [7:0] LAST_ADDR = 8'(N_CH - 1);

  logic              dl_valid [BKG_LAT];
  logic [31:0]       dl_data  [BKG_LAT];
  logic [7:0]        dl_addr  [BKG_LAT];
  logic              al_valid;
  logic [31:0]       al_data;
  logic [7:0]        al_addr;

  logic [HALF_W-1:0] sub_a, sub_b, out_a, out_b;
  logic [HALF_W:0]   peak_cand;
  logic              mode_q, mode_eff;

  state_t            state_q, state_d;
  logic              start, acc_en, err_d;
  logic [7:0]        last_addr;
  logic [ACC_W-1:0]  acc_a, acc_b;
  logic [HALF_W:0]   peak_val;
  logic [7:0]        peak_addr;

  assign bkg_rd_address = data_in.address;

  // Delay line lining each beat up with the background RAM read data.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      for (int i = 0; i < BKG_LAT; i++) begin
        dl_valid[i] <= 1'b0;
        dl_data[i]  <= '0;
        dl_addr[i]  <= '0;
      end
    end else begin
      dl_valid[0] <= data_in.valid & enable;
      dl_data[0]  <= data_in.data;
      dl_addr[0]  <= data_in.address;
      for (int i = 1; i < BKG_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_data[i]  <= dl_data[i-1];
        dl_addr[i]  <= dl_addr[i-1];
      end
    end
  end

  assign al_valid = dl_valid[BKG_LAT-1];
  assign al_data  = dl_data[BKG_LAT-1];
  assign al_addr  = dl_addr[BKG_LAT-1];

  sat_sub16 u_sub_a (.raw(al_data[31:16]), .bkg(bkg_signal[31:16]), .diff(sub_a));
  sat_sub16 u_sub_b (.raw(al_data[15:0]),  .bkg(bkg_signal[15:0]),  .diff(sub_b));

  // The address-0 beat already uses the mode it is latching.
  assign mode_eff  = start ? bkg_sub_status : mode_q;
  assign out_a     = mode_eff ? sub_a : al_data[31:16];
  assign out_b     = mode_eff ? sub_b : al_data[15:0];
  assign peak_cand = {1'b0, out_a} + {1'b0, out_b};
  assign sub_active = mode_q;

  // FSM state register.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state and frame control decoded from the aligned beat.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    acc_en  = 1'b0;
    err_d   = 1'b0;
    if (al_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (al_addr == 8'd0) begin
            start   = 1'b1;
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (al_addr == 8'd0) begin
            start = 1'b1;
            err_d = 1'b1;
          end else if (al_addr == last_addr + 8'd1) begin
            acc_en = 1'b1;
            if (al_addr == LAST_ADDR) state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (al_addr == 8'd0) begin
            start   = 1'b1;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  // Output register, accumulators, peak tracking and result publish.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      data_out.valid   <= 1'b0;
      data_out.data    <= '0;
      data_out.address <= '0;
      frame_err        <= 1'b0;
      frame_done       <= 1'b0;
      frame_sum_a      <= '0;
      frame_sum_b      <= '0;
      frame_peak_addr  <= '0;
      mode_q           <= 1'b0;
      last_addr        <= '0;
      acc_a            <= '0;
      acc_b            <= '0;
      peak_val         <= '0;
      peak_addr        <= '0;
    end else begin
      data_out.valid <= al_valid;
      if (al_valid) begin
        data_out.data    <= {out_a, out_b};
        data_out.address <= al_addr;
      end
      frame_err  <= err_d;
      frame_done <= (state_q == ST_DONE);
      if (start) begin
        mode_q    <= bkg_sub_status;
        last_addr <= al_addr;
        acc_a     <= {{(ACC_W-HALF_W){1'b0}}, out_a};
        acc_b     <= {{(ACC_W-HALF_W){1'b0}}, out_b};
        peak_val  <= peak_cand;
        peak_addr <= al_addr;
      end else if (acc_en) begin
        last_addr <= al_addr;
        acc_a     <= sat_acc(acc_a, out_a);
        acc_b     <= sat_acc(acc_b, out_b);
        // Strict compare keeps the earlier (lower) channel on a tie.
        if (peak_cand > peak_val) begin
          peak_val  <= peak_cand;
          peak_addr <= al_addr;
        end
      end
      if (state_q == ST_DONE) begin
        frame_sum_a     <= acc_a;
        frame_sum_b     <= acc_b;
        frame_peak_addr <= peak_addr;
      end
    end
  end

endmodule

// File: tb/tb_bkg_subtract.sv
// Directed bench for bkg_subtract with N_CH=4, BKG_LAT=2.
module tb_bkg_subtract;
  import bkg_subtract_pkg::*;

  localparam int N_CH    = 4;
  localparam int BKG_LAT = 2;

  logic        clk_clk = 1'b0;
  logic        rst_reset = 1'b1;
  logic        enable = 1'b0;
  logic        bkg_sub_status = 1'b0;
  logic [7:0]  bkg_rd_address;
  logic [31:0] bkg_signal;
  logic [31:0] frame_sum_a, frame_sum_b;
  logic [7:0]  frame_peak_addr;
  logic        frame_done, frame_err, sub_active;

  bkg_subtract_if data_in ();
  bkg_subtract_if data_out ();

  bkg_subtract #(.N_CH(N_CH), .BKG_LAT(BKG_LAT)) dut (
    .clk_clk         (clk_clk),
    .rst_reset       (rst_reset),
    .enable          (enable),
    .data_in         (data_in),
    .bkg_rd_address  (bkg_rd_address),
    .bkg_signal      (bkg_signal),
    .bkg_sub_status  (bkg_sub_status),
    .data_out        (data_out),
    .frame_sum_a     (frame_sum_a),
    .frame_sum_b     (frame_sum_b),
    .frame_peak_addr (frame_peak_addr),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .sub_active      (sub_active)
  );

  always #5 clk_clk = ~clk_clk;

  // Background RAM model with BKG_LAT clocks of read latency.
  logic [31:0] bkg_mem [256];
  logic [31:0] rd_pipe [BKG_LAT];
  always @(posedge clk_clk) begin
    rd_pipe[0] <= bkg_mem[bkg_rd_address];
    for (int i = 1; i < BKG_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bkg_signal = rd_pipe[BKG_LAT-1];

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Output observer, sampled away from the active edge.
  int          out_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          last_out_cyc = 0, done_cyc = 0;
  logic [31:0] out_log [256];
  always @(negedge clk_clk) begin
    if (data_out.valid === 1'b1) begin
      out_cnt++;
      out_log[data_out.address] = data_out.data;
      last_out_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  int in_cyc = 0;
  int o0, d0, e0, last_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [31:0] d);
    data_in.valid   = 1'b1;
    data_in.address = a;
    data_in.data    = d;
    @(posedge clk_clk);
    #1;
    in_cyc = cyc;
    data_in.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic mark();
    o0 = out_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < 256; i++) bkg_mem[i] = v;
  endtask

  initial begin
    data_in.valid   = 1'b0;
    data_in.address = 8'd0;
    data_in.data    = 32'd0;
    fill_mem(32'h0014_0020);

    // Reset, then quiet bus.
    rst_reset = 1'b1;
    idle(3);
    rst_reset = 1'b0;
    idle(5);
    check("rst_out_valid", 32'(data_out.valid), 32'd0);
    check("rst_out_data", data_out.data, 32'd0);
    check("rst_out_addr", 32'(data_out.address), 32'd0);
    check("rst_sum_a", frame_sum_a, 32'd0);
    check("rst_sum_b", frame_sum_b, 32'd0);
    check("rst_peak", 32'(frame_peak_addr), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_sub_active", 32'(sub_active), 32'd0);
    check("rst_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Subtract mode: A 0x64-0x14=0x50, B 0x10<0x20 clamps to 0.
    enable = 1'b1;
    bkg_sub_status = 1'b1;
    mark();
    for (int a = 0; a < N_CH; a++) send(8'(a), 32'h0064_0010);
    last_in = in_cyc;
    idle(6);
    check("sub_out_cnt", 32'(out_cnt - o0), 32'd4);
    for (int a = 0; a < N_CH; a++) check("sub_out_data", out_log[a], 32'h0050_0000);
    check("sub_out_latency", 32'(last_out_cyc - last_in), 32'(BKG_LAT));
    check("sub_done_latency", 32'(done_cyc - last_in), 32'(BKG_LAT + 1));
    check("sub_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("sub_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("sub_sum_a", frame_sum_a, 32'd320);
    check("sub_sum_b", frame_sum_b, 32'd0);
    check("sub_active_on", 32'(sub_active), 32'd1);
    check("sub_peak_tie", 32'(frame_peak_addr), 32'd0);

    // Pass-through mode.
    bkg_sub_status = 1'b0;
    mark();
    for (int a = 0; a < N_CH; a++) send(8'(a), 32'h0064_0010);
    idle(6);
    for (int a = 0; a < N_CH; a++) check("pass_out_data", out_log[a], 32'h0064_0010);
    check("pass_sub_active", 32'(sub_active), 32'd0);
    check("pass_sum_a", frame_sum_a, 32'd400);
    check("pass_sum_b", frame_sum_b, 32'd64);
    check("pass_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Restart mid-frame: 0,1,0,1,2,3; only the last four count.
    bkg_sub_status = 1'b1;
    mark();
    send(8'd0, 32'h1000_1000);
    send(8'd1, 32'h1000_1000);
    for (int a = 0; a < N_CH; a++) send(8'(a), 32'h0070_0030);
    idle(6);
    check("rs_out_cnt", 32'(out_cnt - o0), 32'd6);
    check("rs_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("rs_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("rs_sum_a", frame_sum_a, 32'd368);
    check("rs_sum_b", frame_sum_b, 32'd64);

    // Peak tie between channels 1 and 3 (both 512).
    fill_mem(32'h0000_0000);
    mark();
    send(8'd0, 32'h0005_0005);
    send(8'd1, 32'h0100_0100);
    send(8'd2, 32'h0096_0096);
    send(8'd3, 32'h0180_0080);
    idle(6);
    check("pk_peak", 32'(frame_peak_addr), 32'd1);
    check("pk_sum_a", frame_sum_a, 32'd795);
    check("pk_sum_b", frame_sum_b, 32'd539);
    check("pk_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Non-sequential address aborts; published results hold.
    mark();
    send(8'd0, 32'h0001_0001);
    send(8'd1, 32'h0001_0001);
    send(8'd3, 32'h0001_0001);
    idle(6);
    check("ns_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("ns_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("ns_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("ns_sum_hold", frame_sum_a, 32'd795);
    check("ns_peak_hold", 32'(frame_peak_addr), 32'd1);

    // Enable drops mid-frame; an address-0 beat while disabled is ignored.
    fill_mem(32'h0014_0020);
    mark();
    send(8'd0, 32'h0064_0010);
    send(8'd1, 32'h0064_0010);
    enable = 1'b0;
    send(8'd0, 32'hFFFF_FFFF);
    idle(2);
    enable = 1'b1;
    send(8'd2, 32'h0064_0010);
    send(8'd3, 32'h0064_0010);
    idle(6);
    check("en_out_cnt", 32'(out_cnt - o0), 32'd4);
    check("en_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("en_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("en_sum_a", frame_sum_a, 32'd320);
    check("en_sum_b", frame_sum_b, 32'd0);

    // Reset mid-frame; stray beats before address 0 pass but do not start a frame.
    mark();
    send(8'd0, 32'h0070_0030);
    send(8'd1, 32'h0070_0030);
    rst_reset = 1'b1;
    #2;
    check("mr_async_sum", frame_sum_a, 32'd0);
    check("mr_async_valid", 32'(data_out.valid), 32'd0);
    idle(2);
    rst_reset = 1'b0;
    idle(2);
    send(8'd2, 32'hFFFF_0000);
    send(8'd3, 32'hFFFF_0000);
    for (int a = 0; a < N_CH; a++) send(8'(a), 32'h0070_0030);
    idle(6);
    check("mr_out_cnt", 32'(out_cnt - o0), 32'd6);
    check("mr_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("mr_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("mr_sum_a", frame_sum_a, 32'd368);
    check("mr_sum_b", frame_sum_b, 32'd64);
    check("mr_out_last", out_log[3], 32'h005C_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
